// File: rtl/ps2_cmd_decoder_pkg.sv
// Shared definitions for the PS/2 key-command decoder.
// Contents: scan-code constants (set 2), prefix FSM state type,
//           saturating arithmetic and digit-key lookup helpers.
package ps2_cmd_pkg;

    // Prefix bytes
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_EXT   = 8'hE0;

    // Normal key codes
    localparam logic [7:0] KEY_0     = 8'h45;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3D;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_G     = 8'h34;
    localparam logic [7:0] KEY_B     = 8'h32;
    localparam logic [7:0] KEY_C     = 8'h21;
    localparam logic [7:0] KEY_PLUS  = 8'h79;
    localparam logic [7:0] KEY_MINUS = 8'h7B;
    localparam logic [7:0] KEY_F     = 8'h2B;

    // Extended (E0-prefixed) key codes
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    // Returned by digit_of for a code that is not a digit key
    localparam logic [3:0] NO_DIGIT  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } pfx_state_t;

    // value + delta clamped to [lo, hi]; operands are small so int never overflows
    function automatic int sat_add(input int value, input int delta,
                                   input int lo, input int hi);
        int sum;
        sum = value + delta;
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

    function automatic logic [3:0] digit_of(input logic [7:0] code);
        case (code)
            KEY_0:   return 4'd0;
            KEY_1:   return 4'd1;
            KEY_2:   return 4'd2;
            KEY_3:   return 4'd3;
            KEY_4:   return 4'd4;
            KEY_5:   return 4'd5;
            KEY_6:   return 4'd6;
            KEY_7:   return 4'd7;
            default: return NO_DIGIT;
        endcase
    endfunction

endpackage

// File: rtl/ps2_cmd_decoder_flash_timer.sv
// Flash blink generator: free-running divider while enabled, phase toggles on wrap.
// Ports: clock, reset (sync, active-high), enable (flash on), phase (1 = visible).
// Disabled holds counter 0 / phase 1, so each enable restarts a full visible half-period.
module flash_timer #(
    parameter int FLASH_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic phase
);
    localparam int CNT_W = $clog2(FLASH_DIV);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count <= '0;
            phase <= 1'b1;
        end else if (count == CNT_W'(FLASH_DIV - 1)) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 set-2 key-command decoder driving the character renderer's controls.
// Ports: clock/reset (sync, active-high), codeValid/inCode byte input; registered
//        userNum, charSize, outColor, xOffset, yOffset, enFlash, flashPhase, cmdStrobe (1-cycle latency).
module ps2_cmd_decoder
    import ps2_cmd_pkg::*;
#(
    parameter int OFFSET_W  = 8,
    parameter int SIZE_W    = 5,
    parameter int SIZE_MIN  = 1,
    parameter int SIZE_MAX  = 16,
    parameter int USER_W    = 3,
    parameter int NUM_USERS = 4,
    parameter int STEP      = 1,
    parameter int FLASH_DIV = 25_000_000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       codeValid,
    input  logic [7:0]                 inCode,
    output logic [USER_W-1:0]          userNum,
    output logic [SIZE_W-1:0]          charSize,
    output logic [2:0]                 outColor,
    output logic signed [OFFSET_W-1:0] xOffset,
    output logic signed [OFFSET_W-1:0] yOffset,
    output logic                       enFlash,
    output logic                       flashPhase,
    output logic                       cmdStrobe
);
    localparam int OFF_MAX = (1 <<< (OFFSET_W - 1)) - 1;
    localparam int OFF_MIN = -(1 <<< (OFFSET_W - 1));

    pfx_state_t state, state_nxt;

    // {extended flag, code} of the most recent make; matches mark typematic repeats
    logic [8:0]          last_make, last_nxt;
    logic [USER_W-1:0]   user_nxt;
    logic [SIZE_W-1:0]   size_nxt;
    logic [2:0]          color_nxt;
    logic [OFFSET_W-1:0] x_nxt, y_nxt;
    logic                flash_nxt, strobe_nxt;
    logic                is_make, make_ext, is_repeat;
    logic [3:0]          digit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_make <= '0;
            userNum   <= '0;
            charSize  <= SIZE_W'(SIZE_MIN);
            outColor  <= '0;
            xOffset   <= '0;
            yOffset   <= '0;
            enFlash   <= 1'b0;
            cmdStrobe <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_make <= last_nxt;
            userNum   <= user_nxt;
            charSize  <= size_nxt;
            outColor  <= color_nxt;
            xOffset   <= x_nxt;
            yOffset   <= y_nxt;
            enFlash   <= flash_nxt;
            cmdStrobe <= strobe_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_nxt   = last_make;
        user_nxt   = userNum;
        size_nxt   = charSize;
        color_nxt  = outColor;
        x_nxt      = xOffset;
        y_nxt      = yOffset;
        flash_nxt  = enFlash;
        strobe_nxt = 1'b0;
        is_make    = 1'b0;
        make_ext   = 1'b0;
        is_repeat  = 1'b0;
        digit      = digit_of(inCode);

        // Prefix tracking
        if (codeValid) begin
            case (state)
                IDLE: begin
                    if (inCode == PFX_BRK)      state_nxt = BRK;
                    else if (inCode == PFX_EXT) state_nxt = EXT;
                    else                        is_make   = 1'b1;
                end
                EXT: begin
                    if (inCode == PFX_BRK)      state_nxt = EXT_BRK;
                    else if (inCode == PFX_EXT) state_nxt = EXT;
                    else begin
                        is_make   = 1'b1;
                        make_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    // A doubled F0 keeps waiting for the released key's code
                    if (inCode != PFX_BRK) begin
                        if (last_make == {1'b0, inCode}) last_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (last_make == {1'b1, inCode}) last_nxt = '0;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Command decode for makes
        if (is_make) begin
            is_repeat = (last_make == {make_ext, inCode});
            last_nxt  = {make_ext, inCode};
            if (make_ext) begin
                // Arrows act on every make, so held keys auto-repeat
                case (inCode)
                    KEY_UP: begin
                        y_nxt = OFFSET_W'(sat_add(int'(yOffset), -STEP, OFF_MIN, OFF_MAX));
                        strobe_nxt = 1'b1;
                    end
                    KEY_DOWN: begin
                        y_nxt = OFFSET_W'(sat_add(int'(yOffset), STEP, OFF_MIN, OFF_MAX));
                        strobe_nxt = 1'b1;
                    end
                    KEY_LEFT: begin
                        x_nxt = OFFSET_W'(sat_add(int'(xOffset), -STEP, OFF_MIN, OFF_MAX));
                        strobe_nxt = 1'b1;
                    end
                    KEY_RIGHT: begin
                        x_nxt = OFFSET_W'(sat_add(int'(xOffset), STEP, OFF_MIN, OFF_MAX));
                        strobe_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end else if (!is_repeat) begin
                if (digit != NO_DIGIT) begin
                    if (int'(digit) < NUM_USERS) begin
                        user_nxt   = USER_W'(digit);
                        strobe_nxt = 1'b1;
                    end
                end else begin
                    strobe_nxt = 1'b1;
                    case (inCode)
                        KEY_R:     color_nxt[0] = ~outColor[0];
                        KEY_G:     color_nxt[1] = ~outColor[1];
                        KEY_B:     color_nxt[2] = ~outColor[2];
                        KEY_C:     color_nxt    = '0;
                        KEY_PLUS:  size_nxt = SIZE_W'(sat_add(int'(charSize), 1, SIZE_MIN, SIZE_MAX));
                        KEY_MINUS: size_nxt = SIZE_W'(sat_add(int'(charSize), -1, SIZE_MIN, SIZE_MAX));
                        KEY_F:     flash_nxt    = ~enFlash;
                        default:   strobe_nxt   = 1'b0;
                    endcase
                end
            end
        end
    end

    flash_timer #(
        .FLASH_DIV(FLASH_DIV)
    ) u_flash_timer (
        .clock (clock),
        .reset (reset),
        .enable(enFlash),
        .phase (flashPhase)
    );

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: directed scan-code sequences,
// a key-level behavioural model compared every cycle, plus literal spot checks.
module tb_ps2_cmd_decoder;
    localparam int OFFSET_W  = 8;
    localparam int SIZE_W    = 5;
    localparam int SIZE_MIN  = 1;
    localparam int SIZE_MAX  = 16;
    localparam int USER_W    = 3;
    localparam int NUM_USERS = 4;
    localparam int STEP      = 1;
    localparam int FLASH_DIV = 4;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       codeValid;
    logic [7:0]                 inCode;
    logic [USER_W-1:0]          userNum;
    logic [SIZE_W-1:0]          charSize;
    logic [2:0]                 outColor;
    logic signed [OFFSET_W-1:0] xOffset;
    logic signed [OFFSET_W-1:0] yOffset;
    logic                       enFlash;
    logic                       flashPhase;
    logic                       cmdStrobe;

    ps2_cmd_decoder #(
        .OFFSET_W (OFFSET_W),
        .SIZE_W   (SIZE_W),
        .SIZE_MIN (SIZE_MIN),
        .SIZE_MAX (SIZE_MAX),
        .USER_W   (USER_W),
        .NUM_USERS(NUM_USERS),
        .STEP     (STEP),
        .FLASH_DIV(FLASH_DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .codeValid (codeValid),
        .inCode    (inCode),
        .userNum   (userNum),
        .charSize  (charSize),
        .outColor  (outColor),
        .xOffset   (xOffset),
        .yOffset   (yOffset),
        .enFlash   (enFlash),
        .flashPhase(flashPhase),
        .cmdStrobe (cmdStrobe)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (key-event level) ----------------
    int  digit_codes [8] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D};
    bit  model_ready = 0;
    bit  pend_brk, pend_ext;
    int  m_last;                 // ext*256 + code of last make, -1 = none
    int  m_user, m_size, m_color, m_x, m_y, m_flash, m_strobe, m_cnt;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_make(input bit ext, input int code);
        int key;
        bit rep;
        int omax, omin;
        omax = (1 << (OFFSET_W - 1)) - 1;
        omin = -(1 << (OFFSET_W - 1));
        key  = (ext ? 256 : 0) + code;
        rep  = (key == m_last);
        m_last = key;
        if (ext) begin
            case (code)
                'h75: begin m_y = clamp(m_y - STEP, omin, omax); m_strobe = 1; end
                'h72: begin m_y = clamp(m_y + STEP, omin, omax); m_strobe = 1; end
                'h6B: begin m_x = clamp(m_x - STEP, omin, omax); m_strobe = 1; end
                'h74: begin m_x = clamp(m_x + STEP, omin, omax); m_strobe = 1; end
                default: ;
            endcase
        end else if (!rep) begin
            for (int i = 0; i < 8; i++)
                if (digit_codes[i] == code && i < NUM_USERS) begin
                    m_user = i;
                    m_strobe = 1;
                end
            case (code)
                'h2D: begin m_color = m_color ^ 1; m_strobe = 1; end
                'h34: begin m_color = m_color ^ 2; m_strobe = 1; end
                'h32: begin m_color = m_color ^ 4; m_strobe = 1; end
                'h21: begin m_color = 0; m_strobe = 1; end
                'h79: begin m_size = clamp(m_size + 1, SIZE_MIN, SIZE_MAX); m_strobe = 1; end
                'h7B: begin m_size = clamp(m_size - 1, SIZE_MIN, SIZE_MAX); m_strobe = 1; end
                'h2B: begin m_flash = 1 - m_flash; m_strobe = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic model_step();
        int old_flash;
        int key;
        if (reset) begin
            model_ready = 1;
            pend_brk = 0; pend_ext = 0; m_last = -1;
            m_user = 0; m_size = SIZE_MIN; m_color = 0; m_x = 0; m_y = 0;
            m_flash = 0; m_strobe = 0; m_cnt = 0;
        end else if (model_ready) begin
            old_flash = m_flash;
            m_strobe = 0;
            if (codeValid) begin
                if (pend_brk) begin
                    key = (pend_ext ? 256 : 0) + int'(inCode);
                    if (!(inCode == 8'hF0 && !pend_ext)) begin
                        if (m_last == key) m_last = -1;
                        pend_brk = 0;
                        pend_ext = 0;
                    end
                end else if (inCode == 8'hF0) begin
                    pend_brk = 1;
                end else if (inCode == 8'hE0) begin
                    pend_ext = 1;
                end else begin
                    model_make(pend_ext, int'(inCode));
                    pend_ext = 0;
                end
            end
            // cycles since flash was switched on; phase alternates every FLASH_DIV
            if (old_flash != 0) m_cnt++;
            else                m_cnt = 0;
        end
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (model_ready) begin
            check("userNum",    int'(userNum),    m_user);
            check("charSize",   int'(charSize),   m_size);
            check("outColor",   int'(outColor),   m_color);
            check("xOffset",    int'(xOffset),    m_x);
            check("yOffset",    int'(yOffset),    m_y);
            check("enFlash",    int'(enFlash),    m_flash);
            check("flashPhase", int'(flashPhase), ((m_cnt / FLASH_DIV) % 2 == 0) ? 1 : 0);
            check("cmdStrobe",  int'(cmdStrobe),  m_strobe);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        codeValid = 1'b1;
        inCode    = b;
    endtask

    task automatic idle();
        @(negedge clock);
        codeValid = 1'b0;
        inCode    = 8'h00;
    endtask

    initial begin
        reset     = 1'b1;
        codeValid = 1'b0;
        inCode    = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("rst_userNum",    int'(userNum),    0);
        check("rst_charSize",   int'(charSize),   1);
        check("rst_outColor",   int'(outColor),   0);
        check("rst_xOffset",    int'(xOffset),    0);
        check("rst_yOffset",    int'(yOffset),    0);
        check("rst_enFlash",    int'(enFlash),    0);
        check("rst_flashPhase", int'(flashPhase), 1);
        check("rst_cmdStrobe",  int'(cmdStrobe),  0);
        reset = 1'b0;

        // user select
        send(8'h16); idle();
        check("user_1", int'(userNum), 1);
        check("user_1_strobe", int'(cmdStrobe), 1);
        send(8'hF0); send(8'h16);
        send(8'h45); idle();
        check("user_0", int'(userNum), 0);
        send(8'hF0); send(8'h45);
        send(8'h2E); idle();
        check("user_5_rejected", int'(userNum), 0);
        check("user_5_no_strobe", int'(cmdStrobe), 0);
        send(8'hF0); send(8'h2E);

        // colour toggles and repeat filter
        send(8'h2D); idle();
        check("red_on", int'(outColor), 1);
        send(8'hF0); send(8'h2D); send(8'h2D); idle();
        check("red_off", int'(outColor), 0);
        send(8'hF0); send(8'h2D);
        send(8'h2D); send(8'h2D); idle();
        check("red_repeat_filtered", int'(outColor), 1);
        check("repeat_no_strobe", int'(cmdStrobe), 0);
        send(8'hF0); send(8'h2D);
        @(negedge clock); codeValid = 1'b0; inCode = 8'h34;   // byte without valid
        idle();
        check("invalid_ignored", int'(outColor), 1);
        send(8'h34); send(8'h32); idle();
        check("green_blue", int'(outColor), 7);
        send(8'h21); idle();
        check("clear_color", int'(outColor), 0);
        send(8'hF0); send(8'h21);

        // right arrow auto-repeat up to saturation
        for (int i = 0; i < 130; i++) begin
            send(8'hE0); send(8'h74);
        end
        idle();
        check("x_saturated", int'(xOffset), 127);
        send(8'hE0); send(8'hF0); send(8'h74); idle();
        check("x_after_break", int'(xOffset), 127);
        check("break_no_strobe", int'(cmdStrobe), 0);
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h72); idle();
        check("x_left", int'(xOffset), 126);
        check("y_down", int'(yOffset), 1);

        // size saturation both ends
        send(8'h7B); idle();
        check("size_min_hold", int'(charSize), 1);
        send(8'hF0); send(8'h7B);
        for (int i = 0; i < 20; i++) begin
            send(8'h79); send(8'hF0); send(8'h79);
        end
        idle();
        check("size_max_hold", int'(charSize), 16);

        // flash timing
        send(8'h2B); idle();
        check("flash_on", int'(enFlash), 1);
        for (int i = 0; i < 8; i++) begin
            check("flash_pattern", int'(flashPhase), (i < 4) ? 1 : 0);
            @(negedge clock);
        end
        send(8'hF0); send(8'h2B); send(8'h2B); idle();
        check("flash_off", int'(enFlash), 0);
        idle();
        check("flash_off_phase", int'(flashPhase), 1);
        send(8'hF0); send(8'h2B);

        // reset discards a pending extended prefix
        send(8'hE0); idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        send(8'h75); idle();
        check("reset_ext_discard_y", int'(yOffset), 0);
        check("reset_ext_no_strobe", int'(cmdStrobe), 0);
        send(8'h16); idle();
        check("idle_after_reset", int'(userNum), 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
